// File: rtl/tanh_act_pkg.sv
// Shared definitions for the 4-bit tanh activation path: code range and the
// round-half-up / saturate helper used by the input quantizer and its benches.
package tanh_act_pkg;

    localparam int TANH_IN_W = 4;
    localparam int Q_MAX     = 7;
    localparam int Q_MIN     = -8;

    // Working width for the rounding add: any IN_W up to 32 plus one guard bit.
    localparam int RS_W = 33;

    typedef struct packed {
        logic [TANH_IN_W-1:0] q;
        logic                 sat;
    } q4_res_t;

    function automatic q4_res_t round_sat_q4(input logic signed [RS_W-1:0] x,
                                             input int unsigned           frac_shift);
        logic signed [RS_W-1:0] w_half;
        logic signed [RS_W-1:0] w_t;
        q4_res_t                r_res;
        w_half    = RS_W'(1) <<< (frac_shift - 1);
        w_t       = (x + w_half) >>> frac_shift;
        r_res.sat = (w_t > RS_W'(Q_MAX)) || (w_t < RS_W'(Q_MIN));
        if (w_t > RS_W'(Q_MAX)) begin
            r_res.q = TANH_IN_W'(Q_MAX);
        end else if (w_t < RS_W'(Q_MIN)) begin
            r_res.q = TANH_IN_W'(Q_MIN);
        end else begin
            r_res.q = w_t[TANH_IN_W-1:0];
        end
        return r_res;
    endfunction

endpackage

// File: rtl/act_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main output register M plus skid
// register S. Ready toward the source is registered (~S valid) only.
module act_skid_buf #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_m_data;
    logic         r_m_vld;
    logic [W-1:0] r_s_data;
    logic         r_s_vld;
    logic         w_accept;
    logic         w_m_free;

    assign o_ready  = ~r_s_vld;
    assign o_data   = r_m_data;
    assign o_valid  = r_m_vld;
    assign w_accept = i_valid & ~r_s_vld;
    assign w_m_free = ~r_m_vld | i_ready;

    // An accept only happens with S empty, so a new sample never has to
    // overtake S: it lands in M when M frees up, otherwise it parks in S.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
            r_s_vld  <= 1'b0;
        end else if (w_accept) begin
            if (w_m_free) begin
                r_m_data <= i_data;
                r_m_vld  <= 1'b1;
            end else begin
                r_s_vld  <= 1'b1;
            end
        end else if (i_ready) begin
            if (r_s_vld) begin
                r_m_data <= r_s_data;
                r_s_vld  <= 1'b0;
            end else begin
                r_m_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && !w_m_free) begin
            r_s_data <= i_data;
        end
    end

endmodule

// File: rtl/tanh4_input_quantizer.sv
// Rounds/saturates signed accumulator samples to 4-bit codes for the tanh stage,
// buffers them in a skid buffer and counts saturation events.
module tanh4_input_quantizer
    import tanh_act_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int FRAC_SHIFT = 4,
    parameter int SATC_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] In,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [TANH_IN_W-1:0]   Out1,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   sat_clr,
    output logic [SATC_W-1:0]      sat_count
);

    logic signed [RS_W-1:0] w_x;
    q4_res_t                w_res;
    logic                   w_accept;
    logic [SATC_W-1:0]      r_sat_cnt;

    // Sign-extend before the rounding add so the max positive input cannot wrap.
    assign w_x      = RS_W'(In);
    assign w_res    = round_sat_q4(w_x, FRAC_SHIFT);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_accept && w_res.sat && !(&r_sat_cnt)) begin
            r_sat_cnt <= r_sat_cnt + SATC_W'(1);
        end
    end

    assign sat_count = r_sat_cnt;

    act_skid_buf #(
        .W (TANH_IN_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_data  (w_res.q),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (Out1),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

endmodule

// File: tb/tb_tanh4_input_quantizer.sv
// Directed and scoreboard checks for tanh4_input_quantizer (IN_W=8, FRAC_SHIFT=4).
module tb_tanh4_input_quantizer;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] In;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Out1;
    logic              out_valid;
    logic              out_ready;
    logic              sat_clr;
    logic [15:0]       sat_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  stim[$];
    logic [3:0]  exp_q[$];
    int          last_cycles;
    int          last_nout;

    always #5 clk = ~clk;

    tanh4_input_quantizer #(
        .IN_W       (8),
        .FRAC_SHIFT (4),
        .SATC_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .In        (In),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out1      (Out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_q(input logic [7:0] v);
        int t;
        t = (int'($signed(v)) + 8) >>> 4;
        if (t > 7) return 4'h7;
        if (t < -8) return 4'h8;
        return t[3:0];
    endfunction

    // One isolated sample: appears the cycle after acceptance, then nothing follows.
    task automatic xfer(input string tag, input logic [7:0] v, input logic [3:0] eq,
                        input logic [15:0] esat);
        In       = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_vld"}, out_valid, 1);
        check_eq({tag, "_q"}, Out1, eq);
        check_eq({tag, "_sat"}, sat_count, esat);
        tick();
        check_eq({tag, "_empty"}, out_valid, 0);
    endtask

    // mode 0: always ready/valid; 1: random handshakes; 2: out_ready low for 3 cycles
    task automatic stream(input string tag, input int mode, input int budget);
        int         idx;
        int         n_out;
        int         cyc;
        logic       held_v;
        logic [3:0] held_d;
        idx    = 0;
        n_out  = 0;
        held_v = 1'b0;
        held_d = 4'h0;
        exp_q.delete();
        for (cyc = 0; cyc < budget && n_out < stim.size(); cyc++) begin
            in_valid  = (idx < stim.size()) && (mode != 1 || $urandom_range(0, 9) < 7);
            In        = (idx < stim.size()) ? stim[idx] : 8'h00;
            out_ready = (mode == 2) ? (cyc >= 3) :
                        (mode == 1) ? ($urandom_range(0, 9) < 6) : 1'b1;
            if (mode == 2 && cyc == 2) check_eq("bp_in_ready_low", in_ready, 0);
            if (held_v) begin
                check_eq({tag, "_hold_vld"}, out_valid, 1);
                check_eq({tag, "_hold_q"}, Out1, held_d);
            end
            held_v = out_valid & ~out_ready;
            held_d = Out1;
            if (out_valid && out_ready) begin
                check_eq({tag, "_out_has_ref"}, exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq({tag, "_q"}, Out1, exp_q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_q(stim[idx]));
                idx++;
            end
            tick();
        end
        in_valid    = 1'b0;
        last_cycles = cyc;
        last_nout   = n_out;
        check_eq({tag, "_all_out"}, n_out, stim.size());
    endtask

    initial begin
        reset     = 1'b1;
        In        = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        tick();
        tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_Out1", Out1, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_sat_count", sat_count, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();

        xfer("rnd_24", 8'h18, 4'h2, 16'd0);
        xfer("rnd_23", 8'h17, 4'h1, 16'd0);
        xfer("rnd_m8", 8'hF8, 4'h0, 16'd0);
        xfer("sat_7f", 8'h7F, 4'h7, 16'd1);
        xfer("min_80", 8'h80, 4'h8, 16'd1);
        // 0x74 rounds to exactly 7: in range, so no saturation event
        xfer("edge_74", 8'h74, 4'h7, 16'd1);
        xfer("sat_78", 8'h78, 4'h7, 16'd2);

        stim.delete();
        for (int i = 1; i <= 4; i++) stim.push_back(8'(i * 16));
        stream("bp", 2, 50);
        check_eq("bp_out_count", last_nout, 4);
        tick();
        check_eq("bp_no_dup", out_valid, 0);

        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(8'(i));
        stream("tput", 0, 400);
        check_eq("tput_cycles", last_cycles, 257);

        stim.delete();
        for (int i = 0; i < 200; i++) stim.push_back(8'($urandom));
        stream("rand", 1, 4000);
        out_ready = 1'b1;
        tick();
        tick();

        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check_eq("clr_idle", sat_count, 0);
        In       = 8'h7F;
        in_valid = 1'b1;
        repeat (65535) tick();
        check_eq("cnt_full", sat_count, 16'hFFFF);
        repeat (3) tick();
        check_eq("cnt_hold", sat_count, 16'hFFFF);
        sat_clr = 1'b1;
        tick();
        check_eq("clr_priority", sat_count, 0);
        sat_clr  = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("drained", out_valid, 0);

        out_ready = 1'b0;
        In        = 8'h7F;
        in_valid  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_out_valid", out_valid, 1);
        check_eq("full_sat", sat_count, 2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready", in_ready, 1);
        check_eq("arst_sat", sat_count, 0);
        check_eq("arst_Out1", Out1, 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("post_rst_idle", out_valid, 0);
        xfer("post_rst", 8'h30, 4'h3, 16'd0);
        tick();
        check_eq("post_rst_alone", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
